// File: rtl/sat_bpred_pkg.sv
// Shared constants and counter helpers for the bimodal branch predictor.
package sat_bpred_pkg;

   // Byte offset of the instruction word within the PC; index bits start here.
   localparam int PC_OFS = 2;

   function automatic int unsigned cnt_init(input int unsigned cnt_w);
      return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
   endfunction

   function automatic int unsigned cnt_max(input int unsigned cnt_w);
      return (32'd1 << cnt_w) - 32'd1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// One saturating up/down counter of the prediction table, reset to weakly-not-taken.
module sat_counter
   import sat_bpred_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_en,
   input  logic             dec_en,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] INIT = CNT_W'(cnt_init(CNT_W));
   localparam logic [CNT_W-1:0] MAX  = CNT_W'(cnt_max(CNT_W));

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturation is tested before the add/subtract so the counter never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_en && (cnt_q != MAX))
         cnt_d = cnt_q + CNT_W'(1);
      else if (dec_en && (cnt_q != '0))
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= INIT;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/sat_counter_bpred.sv
// Bimodal branch predictor: 2^IDX_W saturating counters, registered prediction, separate train port.
// Optional SAT_BPRED_GSHARE_EN hashes the index with a non-speculative global history register.
module sat_counter_bpred
   import sat_bpred_pkg::*;
#(
   parameter int PC_W   = 32,
   parameter int IDX_W  = 4,
   parameter int CNT_W  = 2,
   parameter int MISS_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [PC_W-1:0]   req_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   output logic [IDX_W-1:0]  pred_idx,
   input  logic              upd_valid,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic              upd_taken,
   input  logic              upd_pred,
   output logic [MISS_W-1:0] miss_cnt
);

   localparam int NENT = 1 << IDX_W;

   logic [NENT-1:0][CNT_W-1:0] cnt;
   logic [NENT-1:0]            inc_en, dec_en;
   logic [IDX_W-1:0]           req_idx;
   logic                       unused_pc;

   logic              pred_valid_q, pred_valid_d;
   logic              pred_taken_q, pred_taken_d;
   logic [IDX_W-1:0]  pred_idx_q, pred_idx_d;
   logic [MISS_W-1:0] miss_q, miss_d;

   assign unused_pc = ^{req_pc[PC_W-1:PC_OFS+IDX_W], req_pc[PC_OFS-1:0]};

`ifdef SAT_BPRED_GSHARE_EN
   logic [IDX_W-1:0] ghr_q, ghr_d;

   assign req_idx = req_pc[PC_OFS+IDX_W-1:PC_OFS] ^ ghr_q;
   assign ghr_d   = upd_valid ? {ghr_q[IDX_W-2:0], upd_taken} : ghr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ghr_q <= '0;
      else     ghr_q <= ghr_d;
   end
`else
   assign req_idx = req_pc[PC_OFS+IDX_W-1:PC_OFS];
`endif

   for (genvar i = 0; i < NENT; i++) begin : g_tbl
      assign inc_en[i] = upd_valid && (upd_idx == IDX_W'(i)) &&  upd_taken;
      assign dec_en[i] = upd_valid && (upd_idx == IDX_W'(i)) && !upd_taken;

      sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk    (clk),
         .rst    (rst),
         .inc_en (inc_en[i]),
         .dec_en (dec_en[i]),
         .cnt    (cnt[i])
      );
   end

   // Reads the current counter value, so a same-edge update is not visible yet.
   always_comb begin
      pred_valid_d = req_valid;
      pred_taken_d = pred_taken_q;
      pred_idx_d   = pred_idx_q;
      if (req_valid) begin
         pred_taken_d = cnt[req_idx][CNT_W-1];
         pred_idx_d   = req_idx;
      end
      miss_d = miss_q;
      if (upd_valid && (upd_pred != upd_taken) && (miss_q != '1))
         miss_d = miss_q + MISS_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_idx_q   <= '0;
         miss_q       <= '0;
      end else begin
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_idx_q   <= pred_idx_d;
         miss_q       <= miss_d;
      end
   end

   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_taken_q;
   assign pred_idx   = pred_idx_q;
   assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_sat_counter_bpred.sv
// Bench for sat_counter_bpred: directed vector table, reset corners, random run against a reference model.
module tb_sat_counter_bpred;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_pc;
   logic        upd_valid;
   logic [3:0]  upd_idx;
   logic        upd_taken;
   logic        upd_pred;

   logic        pred_valid, pred_taken;
   logic [3:0]  pred_idx;
   logic [15:0] miss_cnt;
   logic        pred_valid2, pred_taken2;
   logic [3:0]  pred_idx2;
   logic [1:0]  miss_cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sat_counter_bpred dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .upd_pred(upd_pred), .miss_cnt(miss_cnt)
   );

   sat_counter_bpred #(.MISS_W(2)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
      .pred_valid(pred_valid2), .pred_taken(pred_taken2), .pred_idx(pred_idx2),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .upd_pred(upd_pred), .miss_cnt(miss_cnt2)
   );

   // Reference model: counters as plain integers in 0..3, taken when value >= 2.
   int m_tbl[16];
   int m_miss, m_miss2, m_ghr;
   int m_pv, m_pt, m_pi;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_tbl[i] = 1;
      m_miss = 0; m_miss2 = 0; m_ghr = 0;
      m_pv = 0; m_pt = 0; m_pi = 0;
   endtask

   task automatic model_edge();
      int idx;
      if (req_valid) begin
         idx  = ((int'(req_pc) / 4) % 16) ^ m_ghr;
         m_pv = 1;
         m_pi = idx;
         m_pt = (m_tbl[idx] >= 2) ? 1 : 0;
      end else begin
         m_pv = 0;
      end
      if (upd_valid) begin
         if (upd_taken) m_tbl[upd_idx] = (m_tbl[upd_idx] < 3) ? m_tbl[upd_idx] + 1 : 3;
         else           m_tbl[upd_idx] = (m_tbl[upd_idx] > 0) ? m_tbl[upd_idx] - 1 : 0;
         if (upd_pred != upd_taken) begin
            if (m_miss  < 65535) m_miss++;
            if (m_miss2 < 3)     m_miss2++;
         end
`ifdef SAT_BPRED_GSHARE_EN
         m_ghr = (m_ghr * 2 + int'(upd_taken)) % 16;
`endif
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic [31:0] pc, input logic uv,
                        input logic [3:0] ui, input logic ut, input logic up);
      req_valid = rv; req_pc = pc; upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_pred = up;
   endtask

   // Apply one cycle, advance the model on the edge, compare on the following negedge.
   task automatic step_model(input string nm);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk({nm, ".valid"}, 32'(pred_valid), 32'(m_pv));
      if (m_pv != 0) begin
         chk({nm, ".taken"}, 32'(pred_taken), 32'(m_pt));
         chk({nm, ".idx"},   32'(pred_idx),   32'(m_pi));
      end
      chk({nm, ".miss"},  32'(miss_cnt),  32'(m_miss));
      chk({nm, ".miss2"}, 32'(miss_cnt2), 32'(m_miss2));
   endtask

   task automatic do_reset();
      drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        rv;
      logic [31:0] pc;
      logic        uv;
      logic [3:0]  ui;
      logic        ut;
      logic        up;
      logic        ev;
      logic        et;
      logic [3:0]  ei;
      int          em;
   } vec_t;

   vec_t vt[15];

   initial begin
      // rv pc uv ui ut up | valid taken idx miss
      vt[0]  = '{1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 0};
      vt[1]  = '{1'b0, 32'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1};
      vt[2]  = '{1'b0, 32'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2};
      vt[3]  = '{1'b0, 32'h00, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2};
      vt[4]  = '{1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 2};
      vt[5]  = '{1'b0, 32'h00, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 2};
      vt[6]  = '{1'b1, 32'h80, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 2};
      vt[7]  = '{1'b0, 32'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 3};
      vt[8]  = '{1'b0, 32'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4};
      vt[9]  = '{1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4};
      vt[10] = '{1'b1, 32'h44, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 5};
      vt[11] = '{1'b1, 32'h44, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 5};
      vt[12] = '{1'b1, 32'h80, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 5};
      vt[13] = '{1'b0, 32'h00, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5};
      vt[14] = '{1'b1, 32'h47, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 5};

      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst.valid", 32'(pred_valid), 32'd0);
      chk("rst.taken", 32'(pred_taken), 32'd0);
      chk("rst.idx",   32'(pred_idx),   32'd0);
      chk("rst.miss",  32'(miss_cnt),   32'd0);
      rst = 1'b0;

`ifdef SAT_BPRED_GSHARE_EN
      drive(1'b0, 32'h0, 1'b1, 4'd0, 1'b1, 1'b1);
      step_model("gs.upd0");
      drive(1'b0, 32'h0, 1'b1, 4'd0, 1'b1, 1'b1);
      step_model("gs.upd1");
      drive(1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0);
      step_model("gs.req");
      chk("gs.hash_idx", 32'(pred_idx), 32'd3);
      do_reset();
`else
      foreach (vt[k]) begin
         drive(vt[k].rv, vt[k].pc, vt[k].uv, vt[k].ui, vt[k].ut, vt[k].up);
         @(posedge clk);
         model_edge();
         @(negedge clk);
         chk($sformatf("vec%0d.valid", k), 32'(pred_valid), 32'(vt[k].ev));
         chk($sformatf("vec%0d.taken", k), 32'(pred_taken), 32'(vt[k].et));
         chk($sformatf("vec%0d.idx",   k), 32'(pred_idx),   32'(vt[k].ei));
         chk($sformatf("vec%0d.miss",  k), 32'(miss_cnt),   32'(vt[k].em));
      end
      chk("miss_w2.sat", 32'(miss_cnt2), 32'd3);
`endif

      // Reset in the middle of a cycle carrying both a request and an update.
      drive(1'b1, 32'h44, 1'b0, 4'd0, 1'b0, 1'b0);
      step_model("pre_rst");
      drive(1'b1, 32'h44, 1'b1, 4'd1, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("midrst.valid",  32'(pred_valid), 32'd0);
      chk("midrst.miss",   32'(miss_cnt),   32'd0);
      chk("midrst.miss2",  32'(miss_cnt2),  32'd0);
      @(negedge clk);
      chk("midrst.hold_valid", 32'(pred_valid), 32'd0);
      model_reset();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 32'(i * 4), 1'b0, 4'd0, 1'b0, 1'b0);
         @(posedge clk);
         model_edge();
         @(negedge clk);
         chk($sformatf("postrst%0d.taken", i), 32'(pred_taken), 32'd0);
         chk($sformatf("postrst%0d.idx", i),   32'(pred_idx),   32'(i));
      end

      // Random traffic with a narrow index range so saturation and collisions occur.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         drive(1'($urandom_range(0, 1)),
               {$urandom_range(0, 255), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom)},
               1'($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)));
         step_model("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
